// File: rtl/grant_decoder.sv
// Grant-side decoder for the TX arbiter: turns a winning index into a
// registered one-hot grant held for one frame, with stall timeout.
module grant_decoder #(
  parameter int DW      = 8,
  parameter int IW      = (DW > 1) ? $clog2(DW) : 1,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel_valid,
  input  logic [IW-1:0] sel_idx,
  output logic          sel_ready,
  input  logic [DW-1:0] ch_valid,
  input  logic [DW-1:0] ch_last,
  input  logic          out_ready,
  output logic [DW-1:0] grant,
  output logic [IW-1:0] mux_idx,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_beats,
  output logic          timeout_err,
  output logic          idx_err
);

  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW:0] DWV = (IW + 1)'(DW);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] grant_n;
  logic [IW-1:0] mux_n;
  logic [15:0]   beats, beats_n, beats_inc, fb_n;
  logic [SW-1:0] stall, stall_n;
  logic          fd_n, to_n, ie_n;
  logic [DW-1:0] vsh, lsh;
  logic          beat, last, idx_ok;

  // Shift rather than index so DW=1 needs no special casing.
  assign vsh       = ch_valid >> mux_idx;
  assign lsh       = ch_last >> mux_idx;
  assign beat      = vsh[0] && out_ready;
  assign last      = lsh[0];
  assign idx_ok    = {1'b0, sel_idx} < DWV;
  assign beats_inc = (beats == 16'hFFFF) ? beats : beats + 16'd1;

  assign sel_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    grant_n = grant;
    mux_n   = mux_idx;
    beats_n = beats;
    stall_n = stall;
    fb_n    = frame_beats;
    fd_n    = 1'b0;
    to_n    = 1'b0;
    ie_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          if (idx_ok) begin
            grant_n = DW'(1) << sel_idx;
            mux_n   = sel_idx;
            beats_n = '0;
            stall_n = '0;
            state_n = GRANT;
          end else begin
            ie_n = 1'b1;
          end
        end
      end
      GRANT: begin
        if (beat) begin
          beats_n = beats_inc;
          stall_n = '0;
          if (last) begin
            fb_n    = beats_inc;
            fd_n    = 1'b1;
            grant_n = '0;
            state_n = RELEASE;
          end
        end else if (TO_EN && stall == STALL_MAX) begin
          to_n    = 1'b1;
          grant_n = '0;
          state_n = RELEASE;
        end else if (TO_EN) begin
          stall_n = stall + 1'b1;
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      mux_idx     <= '0;
      beats       <= '0;
      stall       <= '0;
      frame_beats <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      idx_err     <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      mux_idx     <= mux_n;
      beats       <= beats_n;
      stall       <= stall_n;
      frame_beats <= fb_n;
      frame_done  <= fd_n;
      timeout_err <= to_n;
      idx_err     <= ie_n;
    end
  end

endmodule

// File: tb/tb_grant_decoder.sv
// Bench for grant_decoder: three instances (DW=8/5/1) checked each cycle
// against a frame-level model, plus directed literal checks.
module tb_grant_decoder;

  logic       clk = 1'b0;
  logic       rst, sv, ordy;
  logic [2:0] sidx;
  logic [7:0] cv, cl;

  always #5 clk = ~clk;

  logic [7:0]  g8;
  logic [4:0]  g5;
  logic [0:0]  g1;
  logic [2:0]  mx8, mx5;
  logic [0:0]  mx1;
  logic [15:0] fb[3];
  logic        rdy[3], bsy[3], fd[3], to[3], ie[3];

  grant_decoder #(.DW(8), .TIMEOUT(16)) u8 (
    .clk(clk), .rst(rst), .sel_valid(sv), .sel_idx(sidx),
    .sel_ready(rdy[0]), .ch_valid(cv), .ch_last(cl),
    .out_ready(ordy), .grant(g8), .mux_idx(mx8), .busy(bsy[0]),
    .frame_done(fd[0]), .frame_beats(fb[0]),
    .timeout_err(to[0]), .idx_err(ie[0])
  );

  grant_decoder #(.DW(5), .TIMEOUT(16)) u5 (
    .clk(clk), .rst(rst), .sel_valid(sv), .sel_idx(sidx),
    .sel_ready(rdy[1]), .ch_valid(cv[4:0]), .ch_last(cl[4:0]),
    .out_ready(ordy), .grant(g5), .mux_idx(mx5), .busy(bsy[1]),
    .frame_done(fd[1]), .frame_beats(fb[1]),
    .timeout_err(to[1]), .idx_err(ie[1])
  );

  grant_decoder #(.DW(1), .TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst), .sel_valid(sv), .sel_idx(sidx[0:0]),
    .sel_ready(rdy[2]), .ch_valid(cv[0:0]), .ch_last(cl[0:0]),
    .out_ready(ordy), .grant(g1), .mux_idx(mx1), .busy(bsy[2]),
    .frame_done(fd[2]), .frame_beats(fb[2]),
    .timeout_err(to[2]), .idx_err(ie[2])
  );

  logic [31:0] d_grant[3], d_mux[3];
  assign d_grant[0] = 32'(g8);
  assign d_grant[1] = 32'(g5);
  assign d_grant[2] = 32'(g1);
  assign d_mux[0]   = 32'(mx8);
  assign d_mux[1]   = 32'(mx5);
  assign d_mux[2]   = 32'(mx1);

  int n_vec = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // Model: granted channel (-1 when none), release flag, frame counters.
  int m_gr[3], m_beats[3], m_quiet[3], m_fb[3], m_mux[3];
  bit m_rel[3], m_fd[3], m_to[3], m_ie[3];

  function automatic int dw_of(int i);
    return (i == 0) ? 8 : (i == 1) ? 5 : 1;
  endfunction

  function automatic int to_of(int i);
    return (i == 2) ? 0 : 16;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d t=%0t got %0h expected %0h",
               nm, i, $time, act, exp);
    end
  endtask

  task automatic step(int i);
    int idx, c;
    bit b;
    idx = (i == 2) ? int'(sidx[0]) : int'(sidx);
    m_fd[i] = 0;
    m_to[i] = 0;
    m_ie[i] = 0;
    if (rst) begin
      m_gr[i] = -1; m_rel[i] = 0; m_beats[i] = 0;
      m_quiet[i] = 0; m_fb[i] = 0; m_mux[i] = 0;
    end else if (m_rel[i]) begin
      m_rel[i] = 0;
    end else if (m_gr[i] < 0) begin
      if (sv) begin
        if (idx < dw_of(i)) begin
          m_gr[i] = idx; m_mux[i] = idx;
          m_beats[i] = 0; m_quiet[i] = 0;
        end else begin
          m_ie[i] = 1;
        end
      end
    end else begin
      c = m_gr[i];
      b = cv[c] && ordy;
      if (b) begin
        if (m_beats[i] < 65535) m_beats[i]++;
        m_quiet[i] = 0;
        if (cl[c]) begin
          m_fb[i] = m_beats[i]; m_fd[i] = 1;
          m_gr[i] = -1; m_rel[i] = 1;
        end
      end else begin
        m_quiet[i]++;
        if (to_of(i) != 0 && m_quiet[i] == to_of(i)) begin
          m_to[i] = 1; m_gr[i] = -1; m_rel[i] = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) step(i);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        bit act;
        act = (m_gr[i] >= 0) || m_rel[i];
        chk("grant", i, d_grant[i],
            (m_gr[i] >= 0) ? (32'd1 << m_gr[i]) : 32'd0);
        chk("mux_idx", i, d_mux[i], 32'(m_mux[i]));
        chk("busy", i, 32'(bsy[i]), 32'(act));
        chk("sel_ready", i, 32'(rdy[i]), 32'(!act));
        chk("frame_done", i, 32'(fd[i]), 32'(m_fd[i]));
        chk("frame_beats", i, 32'(fb[i]), 32'(m_fb[i]));
        chk("timeout_err", i, 32'(to[i]), 32'(m_to[i]));
        chk("idx_err", i, 32'(ie[i]), 32'(m_ie[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic release_all();
    sv = 0; cv = 8'hFF; cl = 8'hFF; ordy = 1;
    tick();
    cv = 0; cl = 0; ordy = 0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1; sv = 1; sidx = 3'd2; cv = 0; cl = 0; ordy = 0;
    repeat (3) tick();
    rst = 0; sv = 0;
    look();
    chk("rst_grant", 0, d_grant[0], 32'h0);
    chk("rst_busy", 0, 32'(bsy[0]), 32'h0);
    chk("rst_ready", 0, 32'(rdy[0]), 32'h1);
    tick();
    look();
    chk("rst_nogrant", 0, d_grant[0], 32'h0);

    sv = 1; sidx = 3'd5;
    tick();
    sv = 0;
    look();
    chk("basic_grant", 0, d_grant[0], 32'h20);
    chk("dw5_idx5_err", 1, 32'(ie[1]), 32'h1);
    cv = 8'h20; ordy = 1;
    for (int k = 0; k < 4; k++) begin
      cl = (k == 3) ? 8'h20 : 8'h00;
      tick();
    end
    cv = 0; cl = 0;
    look();
    chk("basic_done", 0, 32'(fd[0]), 32'h1);
    chk("basic_beats", 0, 32'(fb[0]), 32'd4);
    chk("basic_rel_grant", 0, d_grant[0], 32'h0);
    chk("basic_rel_ready", 0, 32'(rdy[0]), 32'h0);
    tick();
    look();
    chk("basic_ready", 0, 32'(rdy[0]), 32'h1);

    sv = 1; sidx = 3'd3;
    tick();
    sv = 0;
    for (int k = 0; k < 8; k++) begin
      cv = 8'h48; cl = 8'h40; ordy = (k % 2 == 0);
      tick();
    end
    look();
    chk("bp_held", 0, d_grant[0], 32'h08);
    cl = 8'h48; ordy = 1;
    tick();
    cv = 0; cl = 0;
    look();
    chk("bp_beats", 0, 32'(fb[0]), 32'd5);
    tick();
    tick();

    sv = 1; sidx = 3'd0;
    tick();
    sv = 0; cv = 0; ordy = 1;
    repeat (15) tick();
    look();
    chk("to_pre_grant", 0, d_grant[0], 32'h1);
    chk("to_pre_err", 0, 32'(to[0]), 32'h0);
    tick();
    look();
    chk("to_err", 0, 32'(to[0]), 32'h1);
    chk("to_nodone", 0, 32'(fd[0]), 32'h0);
    chk("to_beats_kept", 0, 32'(fb[0]), 32'd5);
    chk("to_grant_off", 0, d_grant[0], 32'h0);
    chk("to_disabled", 2, d_grant[2], 32'h1);
    tick();
    release_all();

    sv = 1; sidx = 3'd2;
    tick();
    sv = 0; cv = 0; ordy = 1;
    repeat (15) tick();
    cv = 8'h04;
    tick();
    cv = 0;
    look();
    chk("edge_noto", 0, 32'(to[0]), 32'h0);
    chk("edge_grant", 0, d_grant[0], 32'h04);
    cv = 8'h04; cl = 8'h04;
    tick();
    cv = 0; cl = 0;
    look();
    chk("edge_beats", 0, 32'(fb[0]), 32'd2);
    release_all();

    sv = 1; sidx = 3'd6;
    tick();
    look();
    chk("ill_err", 1, 32'(ie[1]), 32'h1);
    chk("ill_grant", 1, d_grant[1], 32'h0);
    chk("ill_idle", 1, 32'(bsy[1]), 32'h0);
    sidx = 3'd4;
    tick();
    sv = 0;
    look();
    chk("ill_next", 1, d_grant[1], 32'h10);
    release_all();

    sv = 1; sidx = 3'd1;
    tick();
    sv = 0; cv = 8'h02; cl = 0; ordy = 1;
    tick();
    tick();
    cv = 0; rst = 1;
    tick();
    rst = 0;
    look();
    chk("mid_grant", 0, d_grant[0], 32'h0);
    chk("mid_nodone", 0, 32'(fd[0]), 32'h0);
    chk("mid_busy", 0, 32'(bsy[0]), 32'h0);
    sv = 1; sidx = 3'd1;
    tick();
    sv = 0; cv = 8'h02; cl = 8'h02;
    tick();
    cv = 0; cl = 0;
    look();
    chk("mid_restart", 0, 32'(fb[0]), 32'd1);
    release_all();

    for (int c = 0; c < 4000; c++) begin
      bit quiet;
      quiet = (c % 256) < 96;
      rst  = ($urandom_range(0, 299) == 0);
      sv   = ($urandom_range(0, 2) == 0);
      sidx = 3'($urandom);
      cv   = quiet ? 8'($urandom & $urandom & $urandom & $urandom)
                   : 8'($urandom);
      cl   = 8'($urandom & $urandom);
      ordy = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0; sv = 0; cv = 0; cl = 0;
    tick();
    look();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
